des_iterative_core: RTL and testbench
=====================================

# des_iterative_core

Sequential, parametrised DES engine that replaces the fully unrolled combinational encrypt/key-process pair with an iterative datapath. It computes R DES rounds per clock (R set at elaboration) and generates subkeys on the fly rather than holding all sixteen. A per-block mode bit selects encryption or decryption. It sits between a host-side block source and a sink behind valid/ready handshakes on both sides. Bit numbering follows the DES standard: bit 1 is the MSB of every vector.

## Interface
Parameters:
- ROUNDS_PER_CYCLE, 1, rounds computed per clock; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.
- NCYC (localparam), 16/ROUNDS_PER_CYCLE, number of RUN cycles per block.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  input block offered.
- in_ready  output  1  core can accept a block.
- in_mode  input  1  0 = encrypt, 1 = decrypt; sampled on accept.
- in_key  input  [64:1]  64-bit key including parity bits; sampled on accept.
- in_data  input  [64:1]  plaintext or ciphertext; sampled on accept.
- out_valid  output  1  result available.
- out_ready  input  1  sink accepts result.
- out_data  output  [64:1]  result block.
- key_parity_err  output  1  odd-parity violation flag for the key of the current result (see Configuration).

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, the core:
  - latches {L,R} = IP(in_data) and {C,D} = PC1(in_key);
  - latches mode;
  - sets round counter rnd=0;
  - moves to RUN.
- RUN: in_ready=0. Each cycle applies ROUNDS_PER_CYCLE chained rounds, then adds ROUNDS_PER_CYCLE to rnd. After the NCYC-th RUN cycle, out_data is loaded with FP({R16,L16}) (final swap applied) and the state moves to DONE.
- Key schedule, round i = 1..16:
  - Encrypt: rotate C and D left by SHIFT[i], then Ki = PC2(C,D).
  - Decrypt: round 1 uses PC2(C,D) unrotated. For i≥2, rotate C and D right by SHIFT[18-i] before PC2.
  - SHIFT = {1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1}.
- Round function: L' = R; R' = L ^ P(S(E(R) ^ Ki)). All XORs are 48- or 32-bit, with no carries.
- DONE: out_valid=1. out_data and key_parity_err stay stable until out_valid&&out_ready. On that handshake the state returns to IDLE, out_valid drops next cycle, and out_data keeps its value.
- in_valid during RUN or DONE is ignored. The source must hold it, per valid/ready rules.
- Reset (rst_n=0 at a clock edge, any state, including mid-RUN): state goes to IDLE; in_ready=1 and out_valid=0 on the following cycle; out_data=0, key_parity_err=0, rnd=0, L/R/C/D=0. Any block in flight is discarded without output.
- Reset values of outputs: in_ready=1, out_valid=0, out_data=64'h0, key_parity_err=0.

## Timing
- Accept at edge T. RUN occupies cycles T+1..T+NCYC. out_valid is first high in cycle T+NCYC+1.
- Latency from accept to out_valid is NCYC+1 cycles: 17 for R=1, 2 for R=16.
- With out_ready held at 1, the DONE→IDLE handshake takes one cycle, so the next accept is possible at T+NCYC+2. Maximum throughput is one block per NCYC+2 cycles.
- Back-pressure: out_ready=0 holds DONE indefinitely with no data change.
- The critical path scales with ROUNDS_PER_CYCLE. R=16 is a single-cycle unrolled core.

## Configuration
- DES_KEY_PARITY_CHECK_EN defined:
  - on accept, each key byte is checked for odd parity (bits 8k-7..8k);
  - key_parity_err is registered with the block and presented alongside out_data in DONE;
  - encryption proceeds regardless.
- DES_KEY_PARITY_CHECK_EN undefined: the checker is not built and key_parity_err is tied to 0.

## Structure
- Shared package des_pkg holds:
  - permutation tables IP, FP, E, P, PC1, PC2;
  - the eight S-box tables;
  - the SHIFT table;
  - the state enum type;
  - helper functions for permutation and S-box lookup.
- Sub-module des_round (combinational) computes one round plus its subkey-step (L, R, C, D, mode, round index in; next L, R, C, D out). The core instantiates ROUNDS_PER_CYCLE copies in a generate chain.

## Test plan
- Encrypt, R=1: key 64'h133457799BBCDFF1, data 64'h0123456789ABCDEF → out_data 64'h85E813540F0AB405; out_valid first seen 17 cycles after accept.
- Decrypt, R=4: same key, data 64'h85E813540F0AB405, mode=1 → out_data 64'h0123456789ABCDEF at 5 cycles after accept.
- Encrypt, R=16: key 64'h0E329232EA6D0D73, data 64'h8787878787878787 → out_data 64'h0; latency 2.
- Back-pressure: out_ready=0 for 10 cycles in DONE → out_valid and out_data unchanged, in_ready=0 throughout; a new in_valid is not accepted until after the output handshake.
- Reset mid-RUN: rst_n=0 at cycle 5 of a block → next cycle in_ready=1, out_valid=0, out_data=0; no result is ever emitted for that block.
- With DES_KEY_PARITY_CHECK_EN: key 64'h133457799BBCDFF1 → key_parity_err=0; key 64'h133457799BBCDFF0 → key_parity_err=1, and out_data is still the correct DES result for that key.

Source files
------------

// File: rtl/des_pkg.sv
// +--------------------------------------------------------------------------+
// | des_pkg                                                                  |
// | DES tables, state type and permutation / S-box helper functions.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package des_pkg;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = c_ST_IDLE,
        RUN  = c_ST_RUN,
        DONE = c_ST_DONE
    } state_t;

    // Tables use DES numbering: entry value n means source bit n, bit 1 = MSB.
    localparam int c_IP [64] = '{
        58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
        62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
        57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
        61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};

    localparam int c_FP [64] = '{
        40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
        38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
        36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
        34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};

    localparam int c_E [48] = '{
        32,1,2,3,4,5,     4,5,6,7,8,9,     8,9,10,11,12,13,  12,13,14,15,16,17,
        16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};

    localparam int c_P [32] = '{
        16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
        2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};

    localparam int c_PC1 [56] = '{
        57,49,41,33,25,17,9,  1,58,50,42,34,26,18,
        10,2,59,51,43,35,27,  19,11,3,60,52,44,36,
        63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
        14,6,61,53,45,37,29,  21,13,5,28,20,12,4};

    localparam int c_PC2 [48] = '{
        14,17,11,24,1,5,  3,28,15,6,21,10,  23,19,12,4,26,8,  16,7,27,20,13,2,
        41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};

    localparam int c_SHIFT [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    localparam int c_SBOX [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,   0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,   15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,   3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,   13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,   13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,   1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,   13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,   3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,   14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,   11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,   10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,   4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,   13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,   6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,   1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,   2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    function automatic logic [63:0] f_ip(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - c_IP[i])];
        return y;
    endfunction

    function automatic logic [63:0] f_fp(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - c_FP[i])];
        return y;
    endfunction

    function automatic logic [55:0] f_pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - c_PC1[i])];
        return y;
    endfunction

    function automatic logic [47:0] f_pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - c_PC2[i])];
        return y;
    endfunction

    function automatic logic [3:0] f_sbox(input int n, input logic [5:0] b);
        return 4'(c_SBOX[3'(n)][{b[5], b[0], b[4:1]}]);
    endfunction

    // Feistel function: expansion, key mix, S-boxes, P permutation.
    function automatic logic [31:0] f_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] y;
        for (int i = 0; i < 48; i++) x[6'(47 - i)] = r[5'(32 - c_E[i])];
        x = x ^ k;
        for (int n = 0; n < 8; n++) s[5'(31 - 4 * n) -: 4] = f_sbox(n, x[6'(47 - 6 * n) -: 6]);
        for (int i = 0; i < 32; i++) y[5'(31 - i)] = s[5'(32 - c_P[i])];
        return y;
    endfunction

endpackage

`default_nettype wire

// File: rtl/des_iterative_core_round.sv
// +--------------------------------------------------------------------------+
// | des_round                                                                |
// | One combinational DES round plus the matching C/D key-schedule step.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module des_round
    import des_pkg::*;
(
    input  logic [31:0] i_l,
    input  logic [31:0] i_r,
    input  logic [27:0] i_c,
    input  logic [27:0] i_d,
    input  logic        i_mode,
    input  logic [4:0]  i_rnd,
    output logic [31:0] o_l,
    output logic [31:0] o_r,
    output logic [27:0] o_c,
    output logic [27:0] o_d
);

    logic [3:0]  w_idx_enc;
    logic [3:0]  w_idx_dec;
    logic        w_sh2_enc;
    logic        w_sh2_dec;
    logic [47:0] w_k;

    always_comb begin
        w_idx_enc = 4'(i_rnd - 5'd1);
        w_idx_dec = 4'(5'd17 - i_rnd);
        w_sh2_enc = (c_SHIFT[w_idx_enc] == 2);
        w_sh2_dec = (c_SHIFT[w_idx_dec] == 2);
        o_c = i_c;
        o_d = i_d;
        if (!i_mode) begin
            o_c = w_sh2_enc ? {i_c[25:0], i_c[27:26]} : {i_c[26:0], i_c[27]};
            o_d = w_sh2_enc ? {i_d[25:0], i_d[27:26]} : {i_d[26:0], i_d[27]};
        end else if (i_rnd != 5'd1) begin
            // Decryption walks the schedule backwards; round 1 reuses C0/D0.
            o_c = w_sh2_dec ? {i_c[1:0], i_c[27:2]} : {i_c[0], i_c[27:1]};
            o_d = w_sh2_dec ? {i_d[1:0], i_d[27:2]} : {i_d[0], i_d[27:1]};
        end
        w_k = f_pc2({o_c, o_d});
        o_l = i_r;
        o_r = i_l ^ f_f(i_r, w_k);
    end

endmodule

`default_nettype wire

// File: rtl/des_iterative_core.sv
// +--------------------------------------------------------------------------+
// | des_iterative_core                                                       |
// | Iterative DES engine, ROUNDS_PER_CYCLE rounds per clock, valid/ready.    |
// | Optional key parity checker: define DES_KEY_PARITY_CHECK_EN.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module des_iterative_core
    import des_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_mode,
    input  logic [64:1] in_key,
    input  logic [64:1] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [64:1] out_data,
    output logic        key_parity_err
);

    localparam int NCYC = 16 / ROUNDS_PER_CYCLE;

    generate
        if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
              ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rounds
            $error("des_iterative_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_l;
    logic [31:0] r_r;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic        r_mode;
    logic [4:0]  r_rnd;
    logic        w_last;
    logic [63:0] w_ip;
    logic [55:0] w_pc1;

    logic [31:0] w_l [0:ROUNDS_PER_CYCLE];
    logic [31:0] w_r [0:ROUNDS_PER_CYCLE];
    logic [27:0] w_c [0:ROUNDS_PER_CYCLE];
    logic [27:0] w_d [0:ROUNDS_PER_CYCLE];

    assign w_l[0] = r_l;
    assign w_r[0] = r_r;
    assign w_c[0] = r_c;
    assign w_d[0] = r_d;

    generate
        for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_round
            des_round u_round (
                .i_l    (w_l[j]),
                .i_r    (w_r[j]),
                .i_c    (w_c[j]),
                .i_d    (w_d[j]),
                .i_mode (r_mode),
                .i_rnd  (r_rnd + 5'(j + 1)),
                .o_l    (w_l[j+1]),
                .o_r    (w_r[j+1]),
                .o_c    (w_c[j+1]),
                .o_d    (w_d[j+1])
            );
        end
    endgenerate

    assign w_last = (r_rnd == 5'((NCYC - 1) * ROUNDS_PER_CYCLE));
    assign w_ip   = f_ip(in_data);
    assign w_pc1  = f_pc1(in_key);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = RUN;
            end
            RUN:  if (w_last) w_state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_l      <= '0;
            r_r      <= '0;
            r_c      <= '0;
            r_d      <= '0;
            r_mode   <= 1'b0;
            r_rnd    <= '0;
            out_data <= '0;
        end else if (r_state == IDLE && in_valid) begin
            r_l    <= w_ip[63:32];
            r_r    <= w_ip[31:0];
            r_c    <= w_pc1[55:28];
            r_d    <= w_pc1[27:0];
            r_mode <= in_mode;
            r_rnd  <= '0;
        end else if (r_state == RUN) begin
            r_l   <= w_l[ROUNDS_PER_CYCLE];
            r_r   <= w_r[ROUNDS_PER_CYCLE];
            r_c   <= w_c[ROUNDS_PER_CYCLE];
            r_d   <= w_d[ROUNDS_PER_CYCLE];
            r_rnd <= r_rnd + 5'(ROUNDS_PER_CYCLE);
            // Final swap: output block is FP(R16 || L16).
            if (w_last) out_data <= f_fp({w_r[ROUNDS_PER_CYCLE], w_l[ROUNDS_PER_CYCLE]});
        end
    end

`ifdef DES_KEY_PARITY_CHECK_EN
    logic w_key_perr;
    logic r_perr_pend;
    logic r_perr;

    always_comb begin
        w_key_perr = 1'b0;
        for (int k = 0; k < 8; k++) if (!(^in_key[8*k+1 +: 8])) w_key_perr = 1'b1;
    end

    // Flag travels with the block so it only changes together with out_data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perr_pend <= 1'b0;
            r_perr      <= 1'b0;
        end else if (r_state == IDLE && in_valid) begin
            r_perr_pend <= w_key_perr;
        end else if (r_state == RUN && w_last) begin
            r_perr <= r_perr_pend;
        end
    end

    assign key_parity_err = r_perr;
`else
    assign key_parity_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_des_iterative_core.sv
// +--------------------------------------------------------------------------+
// | tb_des_iterative_core                                                    |
// | Directed scoreboard bench over R=1, R=4 and R=16 core instances.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_des_iterative_core;

`ifdef DES_KEY_PARITY_CHECK_EN
    localparam bit c_PAR_ON = 1'b1;
`else
    localparam bit c_PAR_ON = 1'b0;
`endif

    localparam logic [63:0] c_K1   = 64'h133457799BBCDFF1;
    localparam logic [63:0] c_K1B  = 64'h133457799BBCDFF0;
    localparam logic [63:0] c_P1   = 64'h0123456789ABCDEF;
    localparam logic [63:0] c_C1   = 64'h85E813540F0AB405;
    localparam logic [63:0] c_K2   = 64'h0E329232EA6D0D73;
    localparam logic [63:0] c_P2   = 64'h8787878787878787;

    typedef struct {
        logic [63:0] d;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  vld;
    logic [2:0]  rdy_in;
    logic [2:0]  ovld;
    logic [2:0]  perr;
    logic        mode;
    logic [63:0] key;
    logic [63:0] data;
    logic        ordy;
    logic [63:0] od [3];

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    des_iterative_core #(.ROUNDS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(rdy_in[0]), .in_mode(mode),
        .in_key(key), .in_data(data), .out_valid(ovld[0]), .out_ready(ordy),
        .out_data(od[0]), .key_parity_err(perr[0]));

    des_iterative_core #(.ROUNDS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(rdy_in[1]), .in_mode(mode),
        .in_key(key), .in_data(data), .out_valid(ovld[1]), .out_ready(ordy),
        .out_data(od[1]), .key_parity_err(perr[1]));

    des_iterative_core #(.ROUNDS_PER_CYCLE(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .in_ready(rdy_in[2]), .in_mode(mode),
        .in_key(key), .in_data(data), .out_valid(ovld[2]), .out_ready(ordy),
        .out_data(od[2]), .key_parity_err(perr[2]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offers one block and returns at the first negedge after it was accepted.
    task automatic accept(input int s, input logic m, input logic [63:0] k,
                          input logic [63:0] d, input logic [63:0] ed, input logic ee,
                          input bit push);
        int g;
        @(negedge clk);
        mode = m; key = k; data = d; vld[s] = 1'b1;
        g = 0;
        while (!rdy_in[s] && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk($sformatf("accept_timeout_%0d", s), 64'(g >= 200), 64'd0);
        if (push) q.push_back('{ed, ee});
        @(negedge clk);
        vld[s] = 1'b0;
    endtask

    task automatic collect(input int s, input int exp_lat, input string tag);
        int   n;
        exp_t e;
        n = 1;
        while (!ovld[s] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
        e = q.pop_front();
        chk({tag, "_data"}, od[s], e.d);
        chk({tag, "_perr"}, 64'(perr[s]), 64'(e.e));
        if (ordy) begin
            @(negedge clk);
            chk({tag, "_vld_drop"}, 64'(ovld[s]), 64'd0);
            chk({tag, "_rdy_back"}, 64'(rdy_in[s]), 64'd1);
            chk({tag, "_data_keep"}, od[s], e.d);
        end
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0; ordy = 1'b1; vld = '0; mode = 1'b0; key = '0; data = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("rst_in_ready_%0d", s), 64'(rdy_in[s]), 64'd1);
            chk($sformatf("rst_out_valid_%0d", s), 64'(ovld[s]), 64'd0);
            chk($sformatf("rst_out_data_%0d", s), od[s], 64'd0);
            chk($sformatf("rst_perr_%0d", s), 64'(perr[s]), 64'd0);
        end
        rst_n = 1'b1;

        accept(0, 1'b0, c_K1, c_P1, c_C1, 1'b0, 1'b1);
        collect(0, 17, "enc_r1");
        accept(1, 1'b1, c_K1, c_C1, c_P1, 1'b0, 1'b1);
        collect(1, 5, "dec_r4");
        accept(2, 1'b0, c_K2, c_P2, 64'd0, 1'b0, 1'b1);
        collect(2, 2, "enc_r16");
        accept(2, 1'b1, c_K2, 64'd0, c_P2, 1'b0, 1'b1);
        collect(2, 2, "dec_r16");
        accept(0, 1'b0, c_K1B, c_P1, c_C1, c_PAR_ON, 1'b1);
        collect(0, 17, "parity_r1");

        // Back-pressure on the R=4 core while a second block is already offered.
        ordy = 1'b0;
        accept(1, 1'b0, c_K1, c_P1, c_C1, 1'b0, 1'b1);
        collect(1, 5, "bp_first");
        mode = 1'b1; key = c_K1; data = c_C1; vld[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_valid_%0d", i), 64'(ovld[1]), 64'd1);
            chk($sformatf("bp_hold_data_%0d", i), od[1], c_C1);
            chk($sformatf("bp_hold_ready_%0d", i), 64'(rdy_in[1]), 64'd0);
        end
        ordy = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 64'(ovld[1]), 64'd0);
        chk("bp_release_ready", 64'(rdy_in[1]), 64'd1);
        chk("bp_release_data", od[1], c_C1);
        q.push_back('{c_P1, 1'b0});
        @(negedge clk);
        vld[1] = 1'b0;
        collect(1, 5, "bp_second");

        // Reset in the fifth RUN cycle of an R=1 block.
        accept(0, 1'b0, c_K1, c_P1, c_C1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 64'(rdy_in[0]), 64'd1);
        chk("midrst_out_valid", 64'(ovld[0]), 64'd0);
        chk("midrst_out_data", od[0], 64'd0);
        chk("midrst_perr", 64'(perr[0]), 64'd0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (ovld[0]) seen = 1'b1;
        end
        chk("midrst_no_output", 64'(seen), 64'd0);
        accept(0, 1'b0, c_K2, c_P2, 64'd0, 1'b0, 1'b1);
        collect(0, 17, "post_rst_r1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
